output_equalizer: RTL and testbench
===================================

// Module: output_equalizer
// PURPOSE
//  Output-side responder to the frame controller's output_start/output_done handshake.
//  Per frame: builds a 256-entry equalization LUT from the CDF bank selected by
//  output_base_offset, then streams every source pixel through the LUT to the output
//  frame store. Signals completion with a one-cycle output_done pulse.
//  Works on the opposite ping-pong bank from the input/histogram stage.
// PARAMETERS
//  NUM_PIXELS  307200  pixels per frame (must equal the controller's 307200 constant)
//  PIX_AW      19      pixel address width within one bank
//  CDF_W       20      CDF word width
// PORTS
//  clock               in   1       system clock
//  reset_n             in   1       asynchronous, active-low reset
//  output_start        in   1       level request from controller; sampled only in IDLE
//  output_base_offset  in   1       bank select; captured at start
//  Cdf_Min_Out         in   CDF_W   cdf_min for the bank; captured at start
//  Divisor             in   CDF_W   NUM_PIXELS - cdf_min; captured at start
//  output_done         out  1       one-cycle pulse after the last pixel write
//  busy                out  1       high from start capture until the output_done cycle (inclusive)
//  cdf_addr            out  9       {bank, level}; read data arrives 1 cycle later
//  cdf_rdata           in   CDF_W   CDF read data
//  pix_raddr           out  PIX_AW+1 {bank, index}; read data arrives 1 cycle later
//  pix_rdata           in   8       source pixel
//  out_waddr           out  PIX_AW  output pixel index
//  out_wdata           out  8       equalized pixel
//  out_we              out  1       output write strobe
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, LUT contents undefined. Reset mid-frame aborts;
//  the frame is not resumed.
//  States: IDLE -> LUT_RD -> LUT_DIV -> LUT_WR -> (next level: LUT_RD | after 255: STREAM)
//  -> DONE -> REARM -> IDLE.
//  IDLE: output_start=1 -> capture bank, cdf_min, divisor; level=0; busy=1.
//  LUT_RD: drive cdf_addr={bank,level}; cdf_rdata is used on the next cycle.
//  LUT_DIV: dividend = (cdf<cdf_min) ? 0 : (cdf-cdf_min)*255 (28 bits). Restoring
//   divider, 1 bit/cycle, 28 cycles. Quotient >255 saturates to 255.
//   Divisor==0 -> division is skipped and the entry is 255.
//  LUT_WR: lut[level] <= q; level++.
//  STREAM: issue pix_raddr index 0..NUM_PIXELS-1, one per clock.
//   Stage 2 registers lut[pix_rdata]. out_we=1, out_waddr=index-2, 1 pixel/clock.
//   Latency is 2 cycles from address to write. No stalls.
//  DONE: output_done=1 for exactly 1 cycle, the cycle after the final write; busy drops next.
//  REARM: wait for output_start==0 (controller drops it 1 cycle after done), then IDLE.
//   This prevents a stale level from restarting the frame.
//  output_start changes while busy: ignored. Bank/cdf_min/divisor changes after
//  capture: ignored.
//  Index counter never wraps: it stops at NUM_PIXELS-1.
//  Frame latency: 256*(30) + NUM_PIXELS + 3 cycles from start capture to output_done.
// CONFIGURATION
//  EQ_BYPASS_EN defined: adds input port bypass (1 bit), captured at start.
//   bypass=1 -> skip LUT states (IDLE->STREAM) and out_wdata=pix_rdata.
//   All other timing and handshakes are unchanged.
//  EQ_BYPASS_EN undefined: port absent; the LUT is always built.
// TESTING
//  1 Reset mid-STREAM -> all outputs 0 next cycle; no output_done; next start runs a full frame.
//  2 NUM_PIXELS=16, cdf[l]=l+1 for l<16 else 16, cdf_min=1, divisor=15 -> pixel v<16
//    writes (v*255)/15 (v=15 -> 255, v=1 -> 17); output_done pulses once.
//  3 Divisor=0 -> every out_wdata=255; cdf<cdf_min entries -> 0 when divisor!=0.
//  4 Back-to-back frames driven by the controller model with output_base_offset toggling
//    -> cdf_addr[8] and pix_raddr[MSB] follow the bank; exactly one done pulse per frame.
//  5 output_start held high 10 cycles after done -> stays in REARM; no restart until
//    start drops and rises.
//  6 EQ_BYPASS_EN, bypass=1 -> out_wdata==pix_rdata; first out_we 2 cycles after start capture.

Source files
------------

// File: rtl/output_equalizer.sv
// Histogram-equalization output stage: builds a 256-entry LUT from one CDF bank,
// then streams the frame through it. Optional bypass build: EQ_BYPASS_EN.
// Ports: clock, reset_n (async, active-low)
//   output_start, output_base_offset, Cdf_Min_Out, Divisor, [bypass]  - frame request
//   output_done, busy                                                  - handshake status
//   cdf_addr/cdf_rdata, pix_raddr/pix_rdata                            - 1-cycle-latency reads
//   out_waddr, out_wdata, out_we                                       - output pixel writes
module output_equalizer #(
  parameter int NUM_PIXELS = 307200,
  parameter int PIX_AW     = 19,
  parameter int CDF_W      = 20
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              output_start,
  input  logic              output_base_offset,
  input  logic [CDF_W-1:0]  Cdf_Min_Out,
  input  logic [CDF_W-1:0]  Divisor,
`ifdef EQ_BYPASS_EN
  input  logic              bypass,
`endif
  output logic              output_done,
  output logic              busy,
  output logic [8:0]        cdf_addr,
  input  logic [CDF_W-1:0]  cdf_rdata,
  output logic [PIX_AW:0]   pix_raddr,
  input  logic [7:0]        pix_rdata,
  output logic [PIX_AW-1:0] out_waddr,
  output logic [7:0]        out_wdata,
  output logic              out_we
);

  localparam int DVD_W = CDF_W + 8;
  localparam logic [PIX_AW-1:0] LAST_IDX = PIX_AW'(NUM_PIXELS - 1);

  typedef enum logic [2:0] {
    IDLE, LUT_RD, LUT_DIV, LUT_WR, STREAM, DONE, REARM
  } state_t;

  state_t             state_q, state_d;
  logic               bank_q, bank_d;
  logic               byp_q, byp_d;
  logic [CDF_W-1:0]   cmin_q, cmin_d;
  logic [CDF_W-1:0]   div_q, div_d;
  logic [7:0]         level_q, level_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [CDF_W-1:0]   rem_q, rem_d;
  logic [DVD_W-1:0]   quo_q, quo_d;
  logic [PIX_AW-1:0]  idx_q, idx_d;
  logic               last_q, last_d;
  logic               v1_q, v1_d;
  logic [PIX_AW-1:0]  a1_q, a1_d;
  logic               we_q, we_d;
  logic [PIX_AW-1:0]  waddr_q, waddr_d;
  logic [7:0]         wdata_q, wdata_d;

  logic [7:0]         lut_q [256];
  logic               lut_we;
  logic [7:0]         lut_wd;

  logic               issue;
  logic [CDF_W-1:0]   diff;
  logic [DVD_W-1:0]   prod;
  logic [DVD_W-1:0]   dvd;
  logic [CDF_W-1:0]   rem_in;
  logic [CDF_W:0]     sh;
  logic [CDF_W-1:0]   trial;
  logic               ge;
  logic [7:0]         q_sat;

  assign issue       = (state_q == STREAM) && !last_q;
  assign cdf_addr    = (state_q == LUT_RD) ? {bank_q, level_q} : '0;
  assign pix_raddr   = issue ? {bank_q, idx_q} : '0;
  assign output_done = (state_q == DONE);
  assign busy        = (state_q != IDLE) && (state_q != REARM);
  assign out_we      = we_q;
  assign out_waddr   = waddr_q;
  assign out_wdata   = wdata_q;

  // One restoring-division step; the first step loads the dividend
  // (cdf - cdf_min) * 255 straight from the CDF read data.
  always_comb begin
    diff   = cdf_rdata - cmin_q;
    prod   = {diff, 8'h00} - {8'h00, diff};
    dvd    = quo_q;
    rem_in = rem_q;
    if (cnt_q == 5'd0) begin
      dvd    = (cdf_rdata < cmin_q) ? '0 : prod;
      rem_in = '0;
    end
    sh    = {rem_in, dvd[DVD_W-1]};
    ge    = (sh >= {1'b0, div_q});
    trial = sh[CDF_W-1:0] - div_q;
    q_sat = (|quo_q[DVD_W-1:8]) ? 8'hFF : quo_q[7:0];
  end

  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    byp_d   = byp_q;
    cmin_d  = cmin_q;
    div_d   = div_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    idx_d   = idx_q;
    last_d  = last_q;
    v1_d    = 1'b0;
    a1_d    = a1_q;
    lut_we  = 1'b0;
    lut_wd  = (div_q == '0) ? 8'hFF : q_sat;
    we_d    = v1_q;
    waddr_d = a1_q;
    wdata_d = '0;
    if (v1_q)
      wdata_d = byp_q ? pix_rdata : lut_q[pix_rdata];
    unique case (state_q)
      IDLE: begin
        if (output_start) begin
          bank_d  = output_base_offset;
          cmin_d  = Cdf_Min_Out;
          div_d   = Divisor;
          level_d = '0;
          idx_d   = '0;
          last_d  = 1'b0;
`ifdef EQ_BYPASS_EN
          byp_d   = bypass;
`else
          byp_d   = 1'b0;
`endif
          state_d = byp_d ? STREAM : LUT_RD;
        end
      end
      LUT_RD: begin
        cnt_d   = '0;
        state_d = LUT_DIV;
      end
      LUT_DIV: begin
        rem_d = ge ? trial : sh[CDF_W-1:0];
        quo_d = {dvd[DVD_W-2:0], ge};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd27)
          state_d = LUT_WR;
      end
      LUT_WR: begin
        lut_we  = 1'b1;
        level_d = level_q + 8'd1;
        state_d = (level_q == 8'd255) ? STREAM : LUT_RD;
      end
      STREAM: begin
        if (!last_q) begin
          v1_d = 1'b1;
          a1_d = idx_q;
          if (idx_q == LAST_IDX)
            last_d = 1'b1;
          else
            idx_d = idx_q + 1'b1;
        end
        // Leave once the final write is on the port.
        if (last_q && we_q && !v1_q)
          state_d = DONE;
      end
      DONE: state_d = REARM;
      REARM: begin
        if (!output_start)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      bank_q  <= 1'b0;
      byp_q   <= 1'b0;
      cmin_q  <= '0;
      div_q   <= '0;
      level_q <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      v1_q    <= 1'b0;
      a1_q    <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      byp_q   <= byp_d;
      cmin_q  <= cmin_d;
      div_q   <= div_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      v1_q    <= v1_d;
      a1_q    <= a1_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  // LUT storage is not reset; it is fully rewritten every non-bypass frame.
  always_ff @(posedge clock) begin
    if (lut_we)
      lut_q[level_q] <= lut_wd;
  end

endmodule

// File: tb/tb_output_equalizer.sv
// Self-checking bench for output_equalizer (16-pixel frames).
// Table vectors + scoreboard queue; controller modelled by run_frame.
module tb_output_equalizer;

  localparam int N      = 16;
  localparam int AW     = 19;
  localparam int CW     = 20;
  localparam int LUTCYC = 256 * 30;
  localparam int BUDGET = 9000;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          output_start = 1'b0;
  logic          output_base_offset = 1'b0;
  logic [CW-1:0] Cdf_Min_Out = '0;
  logic [CW-1:0] Divisor = '0;
`ifdef EQ_BYPASS_EN
  logic          bypass = 1'b0;
`endif
  logic          output_done;
  logic          busy;
  logic [8:0]    cdf_addr;
  logic [CW-1:0] cdf_rdata = '0;
  logic [AW:0]   pix_raddr;
  logic [7:0]    pix_rdata = '0;
  logic [AW-1:0] out_waddr;
  logic [7:0]    out_wdata;
  logic          out_we;

  output_equalizer #(.NUM_PIXELS(N), .PIX_AW(AW), .CDF_W(CW)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .output_start(output_start),
    .output_base_offset(output_base_offset),
    .Cdf_Min_Out(Cdf_Min_Out),
    .Divisor(Divisor),
`ifdef EQ_BYPASS_EN
    .bypass(bypass),
`endif
    .output_done(output_done),
    .busy(busy),
    .cdf_addr(cdf_addr),
    .cdf_rdata(cdf_rdata),
    .pix_raddr(pix_raddr),
    .pix_rdata(pix_rdata),
    .out_waddr(out_waddr),
    .out_wdata(out_wdata),
    .out_we(out_we)
  );

  always #5 clock = ~clock;

  logic [CW-1:0] cdf_mem [512];
  logic [7:0]    pix_mem [2][N];

  always @(posedge clock) begin
    cdf_rdata <= cdf_mem[cdf_addr];
    pix_rdata <= pix_mem[pix_raddr[AW]][pix_raddr[3:0]];
  end

  typedef struct {
    logic [7:0] pix;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl [N];

  typedef struct {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;
  wr_t sbq [$];

  int n_cmp = 0;
  int n_fail = 0;
  int done_cnt, wr_cnt, busy_cnt, cdf_b1_cnt, pix_b1_cnt, first_we_at;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_ctrl"}, {29'd0, busy, output_done, out_we}, 32'd0);
    chk({nm, "_cdf_addr"}, {23'd0, cdf_addr}, 32'd0);
    chk({nm, "_pix_raddr"}, {12'd0, pix_raddr}, 32'd0);
    chk({nm, "_out_waddr"}, {13'd0, out_waddr}, 32'd0);
    chk({nm, "_out_wdata"}, {24'd0, out_wdata}, 32'd0);
  endtask

  always @(negedge clock) begin
    wr_t e;
    if (busy === 1'b1) busy_cnt++;
    if (output_done === 1'b1) done_cnt++;
    if (cdf_addr[8] === 1'b1) cdf_b1_cnt++;
    if (pix_raddr[AW] === 1'b1) pix_b1_cnt++;
    if (out_we === 1'b1) begin
      wr_cnt++;
      if (first_we_at < 0) first_we_at = busy_cnt;
      if (sbq.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0d data %0d, none required",
                 out_waddr, out_wdata);
      end else begin
        e = sbq.pop_front();
        chk("waddr", {13'd0, out_waddr}, {13'd0, e.a});
        chk("wdata", {24'd0, out_wdata}, {24'd0, e.d});
      end
    end
  end

  function automatic logic [7:0] eq_ref(input int cdf, input int cmin, input int dv);
    longint q;
    if (dv == 0) return 8'd255;
    if (cdf < cmin) return 8'd0;
    q = (longint'(cdf - cmin) * 255) / dv;
    return (q > 255) ? 8'd255 : 8'(q);
  endfunction

  task automatic clear_counters();
    done_cnt = 0; wr_cnt = 0; busy_cnt = 0;
    cdf_b1_cnt = 0; pix_b1_cnt = 0; first_we_at = -1;
  endtask

  task automatic push_expect(input bit bank, input int cmin, input int dv,
                             input bit byp, input bit use_tbl);
    wr_t e;
    int b;
    b = bank ? 1 : 0;
    for (int i = 0; i < N; i++) begin
      e.a = AW'(i);
      if (byp) e.d = pix_mem[b][i];
      else if (use_tbl) e.d = tbl[i].exp;
      else e.d = eq_ref(int'(cdf_mem[b * 256 + int'(pix_mem[b][i])]), cmin, dv);
      sbq.push_back(e);
    end
  endtask

  task automatic start_req(input bit bank, input int cmin, input int dv, input bit byp);
    output_base_offset = bank;
    Cdf_Min_Out = CW'(cmin);
    Divisor = CW'(dv);
`ifdef EQ_BYPASS_EN
    bypass = byp;
`endif
    output_start = 1'b1;
  endtask

  task automatic run_frame(input bit bank, input int cmin, input int dv,
                           input bit byp, input bit use_tbl, input int hold);
    int t;
    int lat;
    @(negedge clock); #1;
    clear_counters();
    push_expect(bank, cmin, dv, byp, use_tbl);
    start_req(bank, cmin, dv, byp);
    // Inputs change after capture must be ignored.
    @(negedge clock); #1;
    output_base_offset = ~bank;
    Cdf_Min_Out = CW'(cmin + 3);
    t = 0;
    while (done_cnt == 0 && t < BUDGET) begin
      @(negedge clock); #1;
      t++;
    end
    if (done_cnt == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout: no output_done after %0d cycles", t);
    end
    lat = busy_cnt;
    repeat (hold) begin
      @(negedge clock); #1;
    end
    if (hold > 0) chk("rearm_no_restart", busy_cnt, lat);
    @(negedge clock); #1;
    output_start = 1'b0;
    repeat (3) begin
      @(negedge clock); #1;
    end
    chk("done_pulses", done_cnt, 1);
    chk("write_count", wr_cnt, N);
    chk("sb_empty", sbq.size(), 0);
    chk("latency", busy_cnt, byp ? N + 3 : LUTCYC + N + 3);
    chk("first_we", first_we_at, byp ? 3 : LUTCYC + 3);
    chk("cdf_bank_reads", cdf_b1_cnt, (bank && !byp) ? 256 : 0);
    chk("pix_bank_reads", pix_b1_cnt, bank ? N : 0);
    sbq.delete();
  endtask

  initial begin
    int t;
    tbl[0]  = '{8'd0,   8'd0};
    tbl[1]  = '{8'd1,   8'd17};
    tbl[2]  = '{8'd2,   8'd34};
    tbl[3]  = '{8'd15,  8'd255};
    tbl[4]  = '{8'd7,   8'd119};
    tbl[5]  = '{8'd8,   8'd136};
    tbl[6]  = '{8'd3,   8'd51};
    tbl[7]  = '{8'd14,  8'd238};
    tbl[8]  = '{8'd4,   8'd68};
    tbl[9]  = '{8'd5,   8'd85};
    tbl[10] = '{8'd200, 8'd255};
    tbl[11] = '{8'd9,   8'd153};
    tbl[12] = '{8'd10,  8'd170};
    tbl[13] = '{8'd11,  8'd187};
    tbl[14] = '{8'd12,  8'd204};
    tbl[15] = '{8'd13,  8'd221};
    for (int i = 0; i < N; i++) begin
      pix_mem[0][i] = tbl[i].pix;
      pix_mem[1][i] = 8'(i * 16);
    end
    for (int l = 0; l < 256; l++) begin
      cdf_mem[l] = (l < 16) ? CW'(l + 1) : CW'(16);
      cdf_mem[256 + l] = CW'(l * 40);
    end
    clear_counters();

    repeat (3) @(negedge clock);
    #1;
    chk_idle("reset");
    reset_n = 1'b1;

    run_frame(1'b0, 1, 15, 1'b0, 1'b1, 10);

    // Abort mid-stream with reset.
    @(negedge clock); #1;
    clear_counters();
    push_expect(1'b0, 1, 15, 1'b0, 1'b1);
    start_req(1'b0, 1, 15, 1'b0);
    t = 0;
    while (wr_cnt < 3 && t < BUDGET) begin
      @(negedge clock); #1;
      t++;
    end
    chk("abort_reached_stream", wr_cnt, 3);
    reset_n = 1'b0;
    output_start = 1'b0;
    #1;
    chk_idle("abort_reset");
    @(negedge clock); #1;
    chk_idle("abort_next");
    reset_n = 1'b1;
    repeat (20) begin
      @(negedge clock); #1;
    end
    chk("abort_no_done", done_cnt, 0);
    chk("abort_idle_busy", {31'd0, busy}, 32'd0);
    sbq.delete();

    run_frame(1'b1, 0, 0, 1'b0, 1'b0, 0);
    run_frame(1'b0, 5, 11, 1'b0, 1'b0, 0);
    run_frame(1'b1, 100, 10100, 1'b0, 1'b0, 0);
`ifdef EQ_BYPASS_EN
    run_frame(1'b1, 0, 0, 1'b1, 1'b0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
